// File: rtl/teclado_escaner.sv
// 4x4 membrane keypad scanner: column strobe, row synchroniser, press/release
// debounce and key decode into digit, cancel (*) and accept (#) pulses.
module teclado_escaner #(
  parameter int CLK_DIV        = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fila_in,
  output logic [3:0] col_out,
  output logic       digito_stb,
  output logic [3:0] digito,
  output logic       tecla_cancelar,
  output logic       tecla_aceptar
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [DW-1:0] CNT_LAST  = DW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {ESCANEO, REBOTE, EMITIR, ESPERA_SOLTAR} estado_t;
  typedef enum logic [1:0] {K_NADA, K_DIGITO, K_CANCELAR, K_ACEPTAR} clase_t;

  typedef struct packed {
    clase_t     clase;
    logic [3:0] valor;
  } tecla_t;

  function automatic tecla_t decodificar(input logic [1:0] r, input logic [1:0] c);
    tecla_t t;
    t.clase = K_NADA;
    t.valor = 4'd0;
    if (c == 2'd3) begin
      t.clase = K_NADA;
    end else if (r != 2'd3) begin
      t.clase = K_DIGITO;
      t.valor = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
    end else begin
      case (c)
        2'd0:    t.clase = K_CANCELAR;
        2'd1:    t.clase = K_DIGITO;
        default: t.clase = K_ACEPTAR;
      endcase
    end
    return t;
  endfunction

  function automatic logic [1:0] fila_idx(input logic [3:0] bajas);
    if (bajas[0])      return 2'd0;
    else if (bajas[1]) return 2'd1;
    else if (bajas[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  logic [3:0]    fila_p0;
  logic [3:0]    filas_s;
  logic [TW-1:0] div_cnt;
  logic          tick;
  estado_t       estado;
  logic [1:0]    col_idx;
  logic [1:0]    fila_r;
  logic [3:0]    patron;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] rel_cnt;
  tecla_t        tecla;

  // Stage p0 -> s: two-flop synchroniser for the asynchronous rows
  always_ff @(posedge clk) begin
    if (!reset) begin
      fila_p0 <= 4'b1111;
      filas_s <= 4'b1111;
    end else begin
      fila_p0 <= fila_in;
      filas_s <= fila_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)                  div_cnt <= '0;
    else if (div_cnt == TICK_LAST) div_cnt <= '0;
    else                         div_cnt <= div_cnt + TW'(1);
  end

  assign tick    = (div_cnt == TICK_LAST);
  assign col_out = ~(4'b0001 << col_idx);
  assign tecla   = decodificar(fila_r, col_idx);

  // The column is frozen from detection until release, so col_idx is the latched column
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado         <= ESCANEO;
      col_idx        <= 2'd0;
      fila_r         <= 2'd0;
      patron         <= 4'b1111;
      deb_cnt        <= '0;
      rel_cnt        <= '0;
      digito_stb     <= 1'b0;
      digito         <= 4'd0;
      tecla_cancelar <= 1'b0;
      tecla_aceptar  <= 1'b0;
    end else begin
      digito_stb     <= 1'b0;
      tecla_cancelar <= 1'b0;
      tecla_aceptar  <= 1'b0;
      case (estado)
        ESCANEO: begin
          if (tick) begin
            if (filas_s == 4'b1111) begin
              col_idx <= col_idx + 2'd1;
            end else if ($onehot(~filas_s)) begin
              patron  <= filas_s;
              fila_r  <= fila_idx(~filas_s);
              deb_cnt <= '0;
              estado  <= REBOTE;
            end else begin
              rel_cnt <= '0;
              estado  <= ESPERA_SOLTAR;
            end
          end
        end
        REBOTE: begin
          if (tick) begin
            if (filas_s == patron) begin
              if (deb_cnt == CNT_LAST) begin
                estado <= EMITIR;
                case (tecla.clase)
                  K_DIGITO: begin
                    digito_stb <= 1'b1;
                    digito     <= tecla.valor;
                  end
                  K_CANCELAR: tecla_cancelar <= 1'b1;
                  K_ACEPTAR:  tecla_aceptar  <= 1'b1;
                  default: ;
                endcase
              end else begin
                deb_cnt <= deb_cnt + DW'(1);
              end
            end else begin
              col_idx <= col_idx + 2'd1;
              estado  <= ESCANEO;
            end
          end
        end
        EMITIR: begin
          rel_cnt <= '0;
          estado  <= ESPERA_SOLTAR;
        end
        ESPERA_SOLTAR: begin
          if (tick) begin
            if (filas_s == 4'b1111) begin
              if (rel_cnt == CNT_LAST) begin
                rel_cnt <= '0;
                col_idx <= col_idx + 2'd1;
                estado  <= ESCANEO;
              end else begin
                rel_cnt <= rel_cnt + DW'(1);
              end
            end else begin
              rel_cnt <= '0;
            end
          end
        end
        default: estado <= ESCANEO;
      endcase
    end
  end

endmodule
